mem_access_seq: RTL and testbench

- Single-outstanding memory access sequencer between the CPU core's load/store unit and the bus system's CPU-side port (address/data/write, read-start, ready flags).
- Turns a core-side request/ready handshake into the bus protocol: one-cycle write strobe or read-start pulse, wait for ready, one-cycle completion pulse.
- Holds one pending request so the core can queue the next access while the current one is in flight.
- Times out stalled accesses and flags them as errors.

---
 rtl/mem_access_seq.sv | 176 +++++++++++++++++
 tb/tb_mem_access_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// Single-outstanding memory access sequencer: core request/ready handshake to bus
// write-strobe / read-start protocol, with a one-entry pending slot and wait timeout.
module mem_access_seq #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [14:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_w,
    output logic        bus_readstart,
    input  logic [31:0] bus_rdata,
    input  logic        bus_readrdy,
    input  logic        bus_saverdy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_WAIT_S = 3'd2,
        S_RD     = 3'd3,
        S_WAIT_R = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pend_valid;
    logic               r_pend_we;
    logic [14:0]        r_pend_addr;
    logic [31:0]        r_pend_wdata;
    logic [14:0]        r_bus_addr;
    logic [31:0]        r_bus_wdata;
    logic               r_bus_w;
    logic               r_bus_readstart;
    logic               r_done;
    logic               r_err;
    logic [31:0]        r_rdata;

    logic               w_accept;
    logic               w_in_wait;
    logic               w_ready_ok;
    logic               w_timeout;
    logic               w_complete;
    logic               w_launch;
    logic               w_launch_we;
    logic [14:0]        w_launch_addr;
    logic [31:0]        w_launch_wdata;
    logic               w_use_req;
    logic               w_pend_take;
    logic               w_pend_load;
    logic               w_cnt_clr;
    logic               w_cnt_inc;

    assign req_ready     = !r_pend_valid;
    assign bus_addr      = r_bus_addr;
    assign bus_wdata     = r_bus_wdata;
    assign bus_w         = r_bus_w;
    assign bus_readstart = r_bus_readstart;
    assign done          = r_done;
    assign err           = r_err;
    assign rdata         = r_rdata;

    // Ready flags only count in the wait state that matches the access type;
    // ready beats timeout when both land on the same edge.
    always_comb begin
        w_accept   = req && !r_pend_valid;
        w_in_wait  = (r_state == S_WAIT_S) || (r_state == S_WAIT_R);
        w_ready_ok = ((r_state == S_WAIT_S) && bus_saverdy) ||
                     ((r_state == S_WAIT_R) && bus_readrdy);
        w_timeout  = w_in_wait && !w_ready_ok && (r_cnt == LAST_WAIT);
        w_complete = w_ready_ok || w_timeout;
        w_cnt_clr  = (r_state == S_WR) || (r_state == S_RD);
        w_cnt_inc  = w_in_wait && !w_complete;
    end

    always_comb begin
        w_next         = r_state;
        w_launch       = 1'b0;
        w_use_req      = 1'b0;
        w_pend_take    = 1'b0;
        w_launch_we    = req_we;
        w_launch_addr  = req_addr;
        w_launch_wdata = req_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_launch  = 1'b1;
                    w_use_req = 1'b1;
                end
            end
            S_WR:     w_next = S_WAIT_S;
            S_RD:     w_next = S_WAIT_R;
            S_WAIT_S, S_WAIT_R: begin
                if (w_complete) begin
                    if (r_pend_valid) begin
                        w_launch       = 1'b1;
                        w_pend_take    = 1'b1;
                        w_launch_we    = r_pend_we;
                        w_launch_addr  = r_pend_addr;
                        w_launch_wdata = r_pend_wdata;
                    end else if (w_accept) begin
                        w_launch  = 1'b1;
                        w_use_req = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default:  w_next = S_IDLE;
        endcase
        if (w_launch) begin
            w_next = w_launch_we ? S_WR : S_RD;
        end
        w_pend_load = w_accept && !w_use_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_pend_valid    <= 1'b0;
            r_cnt           <= '0;
            r_bus_addr      <= '0;
            r_bus_wdata     <= '0;
            r_bus_w         <= 1'b0;
            r_bus_readstart <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_rdata         <= '0;
        end else begin
            r_state         <= w_next;
            r_bus_w         <= w_launch && w_launch_we;
            r_bus_readstart <= w_launch && !w_launch_we;
            r_done          <= w_complete;
            r_err           <= w_timeout;
            if (w_launch) begin
                r_bus_addr  <= w_launch_addr;
                r_bus_wdata <= w_launch_wdata;
            end
            if ((r_state == S_WAIT_R) && bus_readrdy) begin
                r_rdata <= bus_rdata;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_pend_load) begin
                r_pend_valid <= 1'b1;
            end else if (w_pend_take) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Pending payload is qualified by r_pend_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_pend_load) begin
            r_pend_we    <= req_we;
            r_pend_addr  <= req_addr;
            r_pend_wdata <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: one instance with the default timeout and one
// with TIMEOUT=4, both fed the same stimulus.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] bus_rdata = '0;
    logic        bus_readrdy = 1'b0;
    logic        bus_saverdy = 1'b0;

    logic        a_req_ready, a_done, a_err, a_bus_w, a_bus_readstart;
    logic [31:0] a_rdata, a_bus_wdata;
    logic [14:0] a_bus_addr;
    logic        b_req_ready, b_done, b_err, b_bus_w, b_bus_readstart;
    logic [31:0] b_rdata, b_bus_wdata;
    logic [14:0] b_bus_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_seq u_dut (
        .clk(clk), .rst(rst), .req(req), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(a_done), .err(a_err),
        .rdata(a_rdata), .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata), .bus_w(a_bus_w),
        .bus_readstart(a_bus_readstart), .bus_rdata(bus_rdata),
        .bus_readrdy(bus_readrdy), .bus_saverdy(bus_saverdy)
    );

    mem_access_seq #(.TIMEOUT(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(b_done), .err(b_err),
        .rdata(b_rdata), .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_w(b_bus_w),
        .bus_readstart(b_bus_readstart), .bus_rdata(bus_rdata),
        .bus_readrdy(bus_readrdy), .bus_saverdy(bus_saverdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        bus_readrdy = 1'b0;
        bus_saverdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", a_req_ready); end
        checks++; if ({a_bus_w, a_bus_readstart, a_done, a_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {a_bus_w, a_bus_readstart, a_done, a_err}); end
        checks++; if ({a_bus_addr, a_bus_wdata, a_rdata} !== 79'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {a_bus_addr, a_bus_wdata, a_rdata}); end
        checks++; if ({b_req_ready, b_bus_w, b_bus_readstart, b_done, b_err} !== 5'b10000) begin errors++; $display("FAIL reset_dut4 got %b exp 10000", {b_req_ready, b_bus_w, b_bus_readstart, b_done, b_err}); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if ({a_req_ready, a_bus_w, a_bus_readstart, a_done} !== 4'b1000) begin errors++; $display("FAIL reset_release got %b exp 1000", {a_req_ready, a_bus_w, a_bus_readstart, a_done}); end
    endtask

    task automatic test_store();
        req = 1'b1; req_we = 1'b1; req_addr = 15'h0010; req_wdata = 32'hDEADBEEF;
        tick();
        req = 1'b0;
        checks++; if ({a_bus_w, a_bus_readstart, a_done} !== 3'b100) begin errors++; $display("FAIL store_strobe got %b exp 100", {a_bus_w, a_bus_readstart, a_done}); end
        checks++; if (a_bus_addr !== 15'h0010) begin errors++; $display("FAIL store_addr got %h exp 0010", a_bus_addr); end
        checks++; if (a_bus_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata got %h exp deadbeef", a_bus_wdata); end
        tick();
        bus_saverdy = 1'b1;
        checks++; if ({a_bus_w, a_done} !== 2'b00) begin errors++; $display("FAIL store_wait got %b exp 00", {a_bus_w, a_done}); end
        checks++; if (a_bus_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata_held got %h exp deadbeef", a_bus_wdata); end
        tick();
        bus_saverdy = 1'b0;
        checks++; if ({a_done, a_err} !== 2'b10) begin errors++; $display("FAIL store_done got %b exp 10", {a_done, a_err}); end
        tick();
        checks++; if ({a_done, a_bus_w} !== 2'b00) begin errors++; $display("FAIL store_done_pulse got %b exp 00", {a_done, a_bus_w}); end
    endtask

    task automatic test_load();
        int pulses;
        pulses = 0;
        req = 1'b1; req_we = 1'b0; req_addr = 15'h7FFF; req_wdata = 32'h0;
        tick();
        req = 1'b0;
        if (a_bus_readstart) pulses++;
        checks++; if ({a_bus_readstart, a_bus_w} !== 2'b10) begin errors++; $display("FAIL load_start got %b exp 10", {a_bus_readstart, a_bus_w}); end
        tick();
        for (int i = 0; i < 5; i++) begin
            if (a_bus_readstart) pulses++;
            checks++; if ({a_done, a_bus_addr} !== {1'b0, 15'h7FFF}) begin errors++; $display("FAIL load_wait%0d got done=%b addr=%h exp done=0 addr=7fff", i, a_done, a_bus_addr); end
            tick();
        end
        bus_readrdy = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_readrdy = 1'b0; bus_rdata = 32'h0;
        checks++; if ({a_done, a_err} !== 2'b10) begin errors++; $display("FAIL load_done got %b exp 10", {a_done, a_err}); end
        checks++; if (a_rdata !== 32'h12345678) begin errors++; $display("FAIL load_rdata got %h exp 12345678", a_rdata); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL load_start_count got %0d exp 1", pulses); end
        tick();
        checks++; if ({a_done, a_rdata} !== {1'b0, 32'h12345678}) begin errors++; $display("FAIL load_after got %h exp 012345678", {a_done, a_rdata}); end
    endtask

    task automatic test_ready_timeout_tie();
        req = 1'b1; req_we = 1'b0; req_addr = 15'h0123;
        tick();
        req = 1'b0;
        tick();
        bus_saverdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL stray_saverdy%0d got done=%b exp 0", i, b_done); end
        end
        bus_saverdy = 1'b0;
        bus_readrdy = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_readrdy = 1'b0; bus_rdata = 32'h0;
        checks++; if ({b_done, b_err} !== 2'b10) begin errors++; $display("FAIL tie_done got %b exp 10", {b_done, b_err}); end
        checks++; if (b_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL tie_rdata got %h exp cafef00d", b_rdata); end
        tick();
    endtask

    task automatic test_timeout();
        req = 1'b1; req_we = 1'b0; req_addr = 15'h0200;
        tick();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL timeout_wait%0d got done=%b exp 0", i, b_done); end
        end
        tick();
        checks++; if ({b_done, b_err} !== 2'b11) begin errors++; $display("FAIL timeout_done got %b exp 11", {b_done, b_err}); end
        checks++; if (b_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL timeout_rdata got %h exp cafef00d", b_rdata); end
        tick();
        checks++; if ({b_done, b_err, b_req_ready} !== 3'b001) begin errors++; $display("FAIL timeout_idle got %b exp 001", {b_done, b_err, b_req_ready}); end
        req = 1'b1; req_we = 1'b1; req_addr = 15'h0001; req_wdata = 32'h1;
        tick();
        req = 1'b0;
        checks++; if ({b_bus_w, b_bus_addr} !== {1'b1, 15'h0001}) begin errors++; $display("FAIL timeout_restart got %h exp 8001", {b_bus_w, b_bus_addr}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 1'b1; req_we = 1'b1; req_addr = 15'h0042; req_wdata = 32'h11112222;
        tick();
        req_we = 1'b0; req_addr = 15'h0043; req_wdata = 32'h0;
        checks++; if ({a_req_ready, a_bus_w} !== 2'b11) begin errors++; $display("FAIL b2b_first got %b exp 11", {a_req_ready, a_bus_w}); end
        tick();
        req = 1'b0;
        checks++; if ({a_req_ready, a_bus_w, a_bus_readstart} !== 3'b000) begin errors++; $display("FAIL b2b_pending got %b exp 000", {a_req_ready, a_bus_w, a_bus_readstart}); end
        bus_saverdy = 1'b1;
        tick();
        bus_saverdy = 1'b0;
        checks++; if ({a_done, a_err, a_bus_readstart, a_bus_w, a_req_ready} !== 5'b10101) begin errors++; $display("FAIL b2b_overlap got %b exp 10101", {a_done, a_err, a_bus_readstart, a_bus_w, a_req_ready}); end
        checks++; if (a_bus_addr !== 15'h0043) begin errors++; $display("FAIL b2b_addr got %h exp 0043", a_bus_addr); end
        tick();
        checks++; if ({a_done, a_bus_readstart} !== 2'b00) begin errors++; $display("FAIL b2b_wait got %b exp 00", {a_done, a_bus_readstart}); end
        bus_readrdy = 1'b1; bus_rdata = 32'h55AA55AA;
        tick();
        bus_readrdy = 1'b0; bus_rdata = 32'h0;
        checks++; if ({a_done, a_err, a_rdata} !== {2'b10, 32'h55AA55AA}) begin errors++; $display("FAIL b2b_load_done got %h exp 255aa55aa", {a_done, a_err, a_rdata}); end
        tick();
    endtask

    task automatic test_async_reset();
        req = 1'b1; req_we = 1'b0; req_addr = 15'h0006;
        tick();
        req_we = 1'b1; req_addr = 15'h0007; req_wdata = 32'h77777777;
        tick();
        req = 1'b0;
        checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL areset_pending got %b exp 0", a_req_ready); end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if ({a_bus_w, a_bus_readstart, a_done, a_err, a_req_ready} !== 5'b00001) begin errors++; $display("FAIL areset_flags got %b exp 00001", {a_bus_w, a_bus_readstart, a_done, a_err, a_req_ready}); end
        checks++; if ({a_bus_addr, a_bus_wdata, a_rdata} !== 79'd0) begin errors++; $display("FAIL areset_data got %h exp 0", {a_bus_addr, a_bus_wdata, a_rdata}); end
        tick();
        rst = 1'b0;
        bus_readrdy = 1'b1; bus_saverdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({a_done, a_bus_w, a_bus_readstart} !== 3'b000) begin errors++; $display("FAIL areset_dropped%0d got %b exp 000", i, {a_done, a_bus_w, a_bus_readstart}); end
        end
        bus_readrdy = 1'b0; bus_saverdy = 1'b0;
        req = 1'b1; req_we = 1'b1; req_addr = 15'h0ABC; req_wdata = 32'h0BADF00D;
        tick();
        req = 1'b0;
        checks++; if ({a_bus_w, a_bus_addr, a_bus_wdata} !== {1'b1, 15'h0ABC, 32'h0BADF00D}) begin errors++; $display("FAIL areset_store got %h exp 8abc0badf00d", {a_bus_w, a_bus_addr, a_bus_wdata}); end
        bus_saverdy = 1'b1;
        tick();
        tick();
        bus_saverdy = 1'b0;
        checks++; if ({a_done, a_err} !== 2'b10) begin errors++; $display("FAIL areset_store_done got %b exp 10", {a_done, a_err}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_ready_timeout_tie();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
